multicycle_datapath: RTL

Parametrised multi-cycle successor to the single-cycle 20-bit datapath. It executes the same 4-bit-opcode instruction set: ALU, immediate, load/store, five signed branches and jump. Execution is sequenced by an internal FSM instead of an external control unit. Instruction and data memories sit outside the block behind req/ack handshakes, so wait-state memories are supported. It is the CPU core that the top level instantiates beside the memories.

---
 rtl/mcd_pkg.sv | 50 +++++
 rtl/mcd_regfile.sv | 42 ++++
 rtl/multicycle_datapath.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mcd_pkg.sv
// ============================================================================
// Module : mcd_pkg
// Brief  : Opcodes, FSM states and instruction field positions for the
//          multi-cycle 20-bit datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcd_pkg;

    localparam int IR_W    = 20;
    localparam int REG_AW  = 4;
    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 4;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 12;
    localparam int IMM_LSB = 12;
    localparam int JT_LSB  = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BLT  = 4'd8,
        OP_BGT  = 4'd9,
        OP_BLE  = 4'd10,
        OP_BGE  = 4'd11,
        OP_JMP  = 4'd12,
        OP_HALT = 4'd13,
        OP_NOP  = 4'd14,
        OP_ILL  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mcd_regfile.sv
// ============================================================================
// Module : mcd_regfile
// Brief  : 16-entry register file, two combinational reads, one synchronous
//          write; R0 always reads zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcd_regfile
    import mcd_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_AW-1:0]    i_ra_addr,
    output logic [DATA_W-1:0]    o_ra_data,
    input  logic [REG_AW-1:0]    i_rb_addr,
    output logic [DATA_W-1:0]    o_rb_data,
    input  logic                 i_we,
    input  logic [REG_AW-1:0]    i_wa,
    input  logic [DATA_W-1:0]    i_wd
);

    logic [DATA_W-1:0] r_regs [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
    assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/multicycle_datapath.sv
// ============================================================================
// Module : multicycle_datapath
// Brief  : FSM-sequenced multi-cycle CPU core with req/ack instruction and
//          data memory ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_datapath
    import mcd_pkg::*;
#(
    parameter int          DATA_W   = 20,
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    state_e            r_state, w_next;
    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_res;
    logic [PC_W-1:0]   r_pc;
    logic              r_imem_req, r_dmem_req, r_dmem_we, r_illegal;

    opcode_e           w_op;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2, w_rb_addr;
    logic [DATA_W-1:0] w_ra, w_rb, w_imm_d, w_alu;
    logic [PC_W-1:0]   w_imm_pc, w_jtgt, w_pc_inc, w_pc_br, w_pc_exec;
    logic              w_imem_done, w_dmem_done, w_lt, w_eq, w_taken;
    logic              w_retire, w_rf_we, w_is_rr;

    assign w_op     = opcode_e'(r_ir[OP_LSB +: 4]);
    assign w_rd     = r_ir[RD_LSB  +: REG_AW];
    assign w_rs1    = r_ir[RS1_LSB +: REG_AW];
    assign w_rs2    = r_ir[RS2_LSB +: REG_AW];
    assign w_imm_d  = DATA_W'($signed(r_ir[IMM_LSB +: 8]));
    assign w_imm_pc = PC_W'($signed(r_ir[IMM_LSB +: 8]));
    assign w_jtgt   = r_ir[JT_LSB +: PC_W];

    // Register-register ALU ops read rs2 on port B; stores and branches read rd.
    assign w_is_rr   = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_OR);
    assign w_rb_addr = w_is_rr ? w_rs2 : w_rd;

    mcd_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (w_rs1),
        .o_ra_data (w_ra),
        .i_rb_addr (w_rb_addr),
        .o_rb_data (w_rb),
        .i_we      (w_rf_we),
        .i_wa      (w_rd),
        .i_wd      (r_res)
    );

    assign w_imem_done = r_imem_req & imem_ack;
    assign w_dmem_done = r_dmem_req & dmem_ack;

    always_comb begin
        w_alu = r_a + w_imm_d;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            default: w_alu = r_a + w_imm_d;
        endcase
    end

    // Branch operands: B holds R[rd], A holds R[rs1]; compare B against A.
    assign w_lt = $signed(r_b) < $signed(r_a);
    assign w_eq = (r_b == r_a);

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_BEQ:  w_taken = w_eq;
            OP_BLT:  w_taken = w_lt;
            OP_BGT:  w_taken = !w_lt && !w_eq;
            OP_BLE:  w_taken = w_lt || w_eq;
            OP_BGE:  w_taken = !w_lt;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_br   = w_pc_inc + w_imm_pc;
    assign w_pc_exec = (w_op == OP_JMP) ? w_jtgt :
                       (w_taken ? w_pc_br : w_pc_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_rf_we  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_imem_done) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = ((w_op == OP_HALT) || (w_op == OP_ILL)) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: w_next = S_WB;
                    OP_LD, OP_ST:                           w_next = S_MEM;
                    default: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (w_dmem_done) begin
                    w_next   = r_dmem_we ? S_FETCH : S_WB;
                    w_retire = r_dmem_we;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
                w_rf_we  = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_W'(RESET_PC);
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_imem_done) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_a <= w_ra;
                    r_b <= w_rb;
                    if (w_op == OP_ILL) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    r_res     <= w_alu;
                    r_dmem_we <= (w_op == OP_ST);
                    if (w_next == S_FETCH) r_pc <= w_pc_exec;
                end
                S_MEM: begin
                    // Request is raised in the first MEM cycle, dropped after ack.
                    if (w_dmem_done) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) r_pc  <= w_pc_inc;
                        else           r_res <= dmem_rdata;
                    end else begin
                        r_dmem_req <= 1'b1;
                    end
                end
                S_WB:    r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_res;
    assign dmem_wdata = r_b;
    assign pc         = r_pc;
    assign retire     = w_retire;
    assign halted     = (r_state == S_HALT);
    assign illegal    = r_illegal;

endmodule

`default_nettype wire
